// File: rtl/dma_rd_sched.sv
// dma_rd_sched: splits one host-read command into MRRS-capped, 4 KB-safe read requests with tag tracking
module dma_rd_sched #(
    parameter int TAG_NUM    = 32,
    parameter int MRRS_BYTES = 512
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [63:0] cmd_addr,
    input  logic [31:0] cmd_len,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [63:0] req_addr,
    output logic [10:0] req_dw_cnt,
    output logic [7:0]  req_tag,
    input  logic        cpl_end,
    input  logic [7:0]  cpl_tag,
    input  logic [11:0] cpl_length,
    input  logic [12:0] cpl_byte_count,
    output logic        busy,
    output logic        done,
    output logic [5:0]  outstanding,
    output logic        err_tag
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_CPL, DONE} state_t;
    state_t               state_q, state_d;
    logic [63:0]          cur_addr_q, cur_addr_d;
    logic [31:0]          remaining_q, remaining_d;
    logic                 req_valid_q, req_valid_d;
    logic [63:0]          req_addr_q, req_addr_d;
    logic [10:0]          req_dw_cnt_q, req_dw_cnt_d;
    logic [7:0]           req_tag_q, req_tag_d;
    logic [TAG_NUM-1:0]   tags_q, tags_d, free_mask, alloc_mask;
    logic [5:0]           outstanding_q, outstanding_d;
    logic                 err_tag_q, err_tag_d;
    logic [12:0]          boundary, rem_cap, mrrs_cap, chunk;
    logic                 free_found, hs;
    logic [7:0]           free_idx;

    assign hs = req_valid_q && req_ready;

    // chunk = min(remaining, MRRS, bytes left in the current 4 KB page)
    always_comb begin
        boundary = 13'd4096 - {1'b0, cur_addr_q[11:0]};
        rem_cap  = (remaining_q > 32'd4096) ? 13'd4096 : remaining_q[12:0];
        mrrs_cap = (rem_cap < 13'(MRRS_BYTES)) ? rem_cap : 13'(MRRS_BYTES);
        chunk    = (boundary < mrrs_cap) ? boundary : mrrs_cap;
    end

    // tag pool: lowest free tag from the pre-free vector, allocate on handshake, free on final completion
    always_comb begin
        free_found = 1'b0;
        free_idx   = 8'd0;
        for (int i = TAG_NUM - 1; i >= 0; i--) begin
            if (!tags_q[i]) begin
                free_found = 1'b1;
                free_idx   = 8'(i);
            end
        end
        free_mask  = '0;
        alloc_mask = '0;
        err_tag_d  = cpl_end;
        for (int i = 0; i < TAG_NUM; i++) begin
            if (cpl_end && cpl_tag == 8'(i) && tags_q[i]) begin
                err_tag_d    = 1'b0;
                free_mask[i] = ({1'b0, cpl_byte_count} == {cpl_length, 2'b00});
            end
            alloc_mask[i] = hs && req_tag_q == 8'(i);
        end
        tags_d        = (tags_q | alloc_mask) & ~free_mask;
        outstanding_d = 6'd0;
        for (int i = 0; i < TAG_NUM; i++) outstanding_d = outstanding_d + 6'(tags_d[i]);
    end

    // command sequencing and request staging
    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        remaining_d  = remaining_q;
        req_valid_d  = req_valid_q;
        req_addr_d   = req_addr_q;
        req_dw_cnt_d = req_dw_cnt_q;
        req_tag_d    = req_tag_q;
        case (state_q)
            IDLE: if (cmd_valid) begin
                cur_addr_d  = cmd_addr;
                remaining_d = cmd_len;
                state_d     = (cmd_len == 32'd0) ? DONE : ISSUE;
            end
            ISSUE: if (hs) begin
                cur_addr_d  = cur_addr_q + 64'(chunk);
                remaining_d = remaining_q - 32'(chunk);
                req_valid_d = 1'b0;
                if (remaining_q == 32'(chunk)) state_d = WAIT_CPL;
            end else if (!req_valid_q && remaining_q != 32'd0 && free_found) begin
                req_valid_d  = 1'b1;
                req_addr_d   = cur_addr_q;
                req_dw_cnt_d = chunk[12:2];
                req_tag_d    = free_idx;
            end
            WAIT_CPL: if (outstanding_q == 6'd0) state_d = DONE;
            DONE: state_d = IDLE;
        endcase
    end

    // state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cur_addr_q    <= '0;
            remaining_q   <= '0;
            req_valid_q   <= 1'b0;
            req_addr_q    <= '0;
            req_dw_cnt_q  <= '0;
            req_tag_q     <= '0;
            tags_q        <= '0;
            outstanding_q <= '0;
            err_tag_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_addr_q    <= cur_addr_d;
            remaining_q   <= remaining_d;
            req_valid_q   <= req_valid_d;
            req_addr_q    <= req_addr_d;
            req_dw_cnt_q  <= req_dw_cnt_d;
            req_tag_q     <= req_tag_d;
            tags_q        <= tags_d;
            outstanding_q <= outstanding_d;
            err_tag_q     <= err_tag_d;
        end
    end

    assign cmd_ready   = state_q == IDLE;
    assign busy        = state_q != IDLE;
    assign done        = state_q == DONE;
    assign req_valid   = req_valid_q;
    assign req_addr    = req_addr_q;
    assign req_dw_cnt  = req_dw_cnt_q;
    assign req_tag     = req_tag_q;
    assign outstanding = outstanding_q;
    assign err_tag     = err_tag_q;
endmodule

// File: tb/tb_dma_rd_sched.sv
// tb_dma_rd_sched: directed checks of request splitting, tag pool, completion handling and reset
module tb_dma_rd_sched;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [63:0] cmd_addr = '0;
    logic [31:0] cmd_len = '0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [63:0] req_addr;
    logic [10:0] req_dw_cnt;
    logic [7:0]  req_tag;
    logic        cpl_end = 1'b0;
    logic [7:0]  cpl_tag = '0;
    logic [11:0] cpl_length = '0;
    logic [12:0] cpl_byte_count = '0;
    logic        busy, done, err_tag;
    logic [5:0]  outstanding;
    int          n_cmp = 0;
    int          n_err = 0;

    dma_rd_sched #(.TAG_NUM(4), .MRRS_BYTES(512)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_dw_cnt(req_dw_cnt), .req_tag(req_tag),
        .cpl_end(cpl_end), .cpl_tag(cpl_tag), .cpl_length(cpl_length), .cpl_byte_count(cpl_byte_count),
        .busy(busy), .done(done), .outstanding(outstanding), .err_tag(err_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [63:0] a, input logic [31:0] l);
        check("cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        tick();
        cmd_valid = 1'b0;
        check("busy_after_cmd", busy, 1);
    endtask

    task automatic wait_req();
        int n = 0;
        while (!req_valid && n < 20) begin
            tick();
            n++;
        end
        check("req_wait", req_valid, 1);
    endtask

    task automatic accept(input logic [63:0] a, input logic [10:0] dw, input logic [7:0] t);
        wait_req();
        check("req_addr", req_addr, a);
        check("req_dw_cnt", req_dw_cnt, dw);
        check("req_tag", req_tag, t);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        check("req_drop", req_valid, 0);
    endtask

    task automatic cpl(input logic [7:0] t, input logic [11:0] l, input logic [12:0] bc);
        cpl_end        = 1'b1;
        cpl_tag        = t;
        cpl_length     = l;
        cpl_byte_count = bc;
        tick();
        cpl_end = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        check("done_seen", done, 1);
        tick();
        check("done_one_cycle", done, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        #2;
        check("rst_req_valid", req_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_err_tag", err_tag, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // four full-size requests, then final completions
        send_cmd(64'h1000, 32'd2048);
        check("t1_first_req_latency", req_valid, 0);
        tick();
        check("t1_first_req_rise", req_valid, 1);
        for (int i = 0; i < 4; i++) accept(64'h1000 + 64'(i * 512), 11'd128, 8'(i));
        check("t1_outstanding4", outstanding, 4);
        for (int i = 0; i < 4; i++) begin
            cpl(8'(i), 12'd128, 13'd512);
            check("t1_outstanding_dec", outstanding, 6'(3 - i));
            check("t1_no_early_done", done, 0);
        end
        tick();
        check("t1_done_after_zero", done, 1);
        tick();
        check("t1_done_pulse", done, 0);
        check("t1_idle", cmd_ready, 1);

        // 4 KB boundary split
        send_cmd(64'h0F80, 32'd512);
        accept(64'h0F80, 11'd32, 8'd0);
        accept(64'h1000, 11'd96, 8'd1);
        cpl(8'd0, 12'd32, 13'd128);
        cpl(8'd1, 12'd96, 13'd384);
        wait_done();

        // tag pool exhaustion and reuse of a freed tag
        send_cmd(64'h2000, 32'd4096);
        for (int i = 0; i < 4; i++) accept(64'h2000 + 64'(i * 512), 11'd128, 8'(i));
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_stall_valid", req_valid, 0);
        end
        check("t3_stall_outstanding", outstanding, 4);
        cpl(8'd2, 12'd128, 13'd512);
        check("t3_freed_not_same_cycle", req_valid, 0);
        check("t3_outstanding3", outstanding, 3);
        tick();
        check("t3_reuse_valid", req_valid, 1);
        accept(64'h2800, 11'd128, 8'd2);
        cpl(8'd0, 12'd128, 13'd512);
        accept(64'h2A00, 11'd128, 8'd0);
        cpl(8'd1, 12'd128, 13'd512);
        accept(64'h2C00, 11'd128, 8'd1);
        cpl(8'd3, 12'd128, 13'd512);
        accept(64'h2E00, 11'd128, 8'd3);
        for (int i = 0; i < 4; i++) cpl(8'(i), 12'd128, 13'd512);
        check("t3_drained", outstanding, 0);
        wait_done();

        // partial completion keeps the tag, final one frees it
        send_cmd(64'h3000, 32'd512);
        accept(64'h3000, 11'd128, 8'd0);
        cpl(8'd0, 12'd64, 13'd512);
        check("t4_partial_kept", outstanding, 1);
        check("t4_partial_no_err", err_tag, 0);
        cpl(8'd0, 12'd64, 13'd256);
        check("t4_final_freed", outstanding, 0);
        wait_done();

        // bad tags and zero-length command
        cpl(8'd7, 12'd1, 13'd4);
        check("t5_err_out_of_range", err_tag, 1);
        check("t5_outstanding_same", outstanding, 0);
        tick();
        check("t5_err_one_cycle", err_tag, 0);
        cpl(8'd1, 12'd1, 13'd4);
        check("t5_err_not_in_use", err_tag, 1);
        send_cmd(64'h4000, 32'd0);
        check("t5_zero_done", done, 1);
        check("t5_zero_no_req", req_valid, 0);
        tick();
        check("t5_zero_done_pulse", done, 0);
        check("t5_zero_idle", busy, 0);

        // backpressure stability, then reset mid-issue
        send_cmd(64'h5000, 32'd2048);
        accept(64'h5000, 11'd128, 8'd0);
        accept(64'h5200, 11'd128, 8'd1);
        wait_req();
        cpl(8'd0, 12'd128, 13'd512);
        for (int i = 0; i < 4; i++) begin
            check("t6_hold_valid", req_valid, 1);
            check("t6_hold_addr", req_addr, 64'h5400);
            check("t6_hold_dw", req_dw_cnt, 11'd128);
            check("t6_hold_tag", req_tag, 8'd2);
            tick();
        end
        check("t6_hold_outstanding", outstanding, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_req_valid", req_valid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_outstanding", outstanding, 0);
        tick();
        rst_n = 1'b1;
        tick();
        cpl(8'd1, 12'd128, 13'd512);
        check("t6_err_after_reset", err_tag, 1);
        check("t6_outstanding_after_reset", outstanding, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
